// File: rtl/y_quantizer.sv
// y_quantizer: JPEG luma quantizer, one 8x8 block per cycle through a 3-stage pipeline.
// Build macro Y_QUANT_ROUND_EN selects round-half-up in stage 3; without it stage 3 floors.
module y_quantizer (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [10:0] Z11, Z12, Z13, Z14, Z15, Z16, Z17, Z18,
    input  logic [10:0] Z21, Z22, Z23, Z24, Z25, Z26, Z27, Z28,
    input  logic [10:0] Z31, Z32, Z33, Z34, Z35, Z36, Z37, Z38,
    input  logic [10:0] Z41, Z42, Z43, Z44, Z45, Z46, Z47, Z48,
    input  logic [10:0] Z51, Z52, Z53, Z54, Z55, Z56, Z57, Z58,
    input  logic [10:0] Z61, Z62, Z63, Z64, Z65, Z66, Z67, Z68,
    input  logic [10:0] Z71, Z72, Z73, Z74, Z75, Z76, Z77, Z78,
    input  logic [10:0] Z81, Z82, Z83, Z84, Z85, Z86, Z87, Z88,
    output logic        out_enable,
    output logic [10:0] Q11, Q12, Q13, Q14, Q15, Q16, Q17, Q18,
    output logic [10:0] Q21, Q22, Q23, Q24, Q25, Q26, Q27, Q28,
    output logic [10:0] Q31, Q32, Q33, Q34, Q35, Q36, Q37, Q38,
    output logic [10:0] Q41, Q42, Q43, Q44, Q45, Q46, Q47, Q48,
    output logic [10:0] Q51, Q52, Q53, Q54, Q55, Q56, Q57, Q58,
    output logic [10:0] Q61, Q62, Q63, Q64, Q65, Q66, Q67, Q68,
    output logic [10:0] Q71, Q72, Q73, Q74, Q75, Q76, Q77, Q78,
    output logic [10:0] Q81, Q82, Q83, Q84, Q85, Q86, Q87, Q88
);

    // Standard JPEG luminance table, row-major (index 0 = row 1 col 1).
    localparam int unsigned QT [64] = '{
        16, 11, 10, 16, 24, 40, 51, 61,
        12, 12, 14, 19, 26, 58, 60, 55,
        14, 13, 16, 24, 40, 57, 69, 56,
        14, 17, 22, 29, 51, 87, 80, 62,
        18, 22, 37, 56, 68, 109, 103, 77,
        24, 35, 55, 64, 81, 104, 113, 92,
        49, 64, 78, 87, 103, 121, 120, 101,
        72, 92, 95, 98, 112, 100, 103, 99
    };

    // round(4096/q) with halves rounded up; folds to a constant per element.
    function automatic logic [12:0] recip(input int unsigned q);
        return 13'((32'd8192 + q) / (32'd2 * q));
    endfunction

    logic signed [10:0] z_in [64];
    logic signed [23:0] z1_d [64];
    logic signed [23:0] z1_q [64];
    logic signed [23:0] p_d  [64];
    logic signed [23:0] p_q  [64];
    logic        [10:0] q_d  [64];
    logic        [10:0] q_q  [64];
    logic        [2:0]  en_d;
    logic        [2:0]  en_q;

    assign z_in[0]  = Z11; assign z_in[1]  = Z12; assign z_in[2]  = Z13; assign z_in[3]  = Z14;
    assign z_in[4]  = Z15; assign z_in[5]  = Z16; assign z_in[6]  = Z17; assign z_in[7]  = Z18;
    assign z_in[8]  = Z21; assign z_in[9]  = Z22; assign z_in[10] = Z23; assign z_in[11] = Z24;
    assign z_in[12] = Z25; assign z_in[13] = Z26; assign z_in[14] = Z27; assign z_in[15] = Z28;
    assign z_in[16] = Z31; assign z_in[17] = Z32; assign z_in[18] = Z33; assign z_in[19] = Z34;
    assign z_in[20] = Z35; assign z_in[21] = Z36; assign z_in[22] = Z37; assign z_in[23] = Z38;
    assign z_in[24] = Z41; assign z_in[25] = Z42; assign z_in[26] = Z43; assign z_in[27] = Z44;
    assign z_in[28] = Z45; assign z_in[29] = Z46; assign z_in[30] = Z47; assign z_in[31] = Z48;
    assign z_in[32] = Z51; assign z_in[33] = Z52; assign z_in[34] = Z53; assign z_in[35] = Z54;
    assign z_in[36] = Z55; assign z_in[37] = Z56; assign z_in[38] = Z57; assign z_in[39] = Z58;
    assign z_in[40] = Z61; assign z_in[41] = Z62; assign z_in[42] = Z63; assign z_in[43] = Z64;
    assign z_in[44] = Z65; assign z_in[45] = Z66; assign z_in[46] = Z67; assign z_in[47] = Z68;
    assign z_in[48] = Z71; assign z_in[49] = Z72; assign z_in[50] = Z73; assign z_in[51] = Z74;
    assign z_in[52] = Z75; assign z_in[53] = Z76; assign z_in[54] = Z77; assign z_in[55] = Z78;
    assign z_in[56] = Z81; assign z_in[57] = Z82; assign z_in[58] = Z83; assign z_in[59] = Z84;
    assign z_in[60] = Z85; assign z_in[61] = Z86; assign z_in[62] = Z87; assign z_in[63] = Z88;

    assign Q11 = q_q[0];  assign Q12 = q_q[1];  assign Q13 = q_q[2];  assign Q14 = q_q[3];
    assign Q15 = q_q[4];  assign Q16 = q_q[5];  assign Q17 = q_q[6];  assign Q18 = q_q[7];
    assign Q21 = q_q[8];  assign Q22 = q_q[9];  assign Q23 = q_q[10]; assign Q24 = q_q[11];
    assign Q25 = q_q[12]; assign Q26 = q_q[13]; assign Q27 = q_q[14]; assign Q28 = q_q[15];
    assign Q31 = q_q[16]; assign Q32 = q_q[17]; assign Q33 = q_q[18]; assign Q34 = q_q[19];
    assign Q35 = q_q[20]; assign Q36 = q_q[21]; assign Q37 = q_q[22]; assign Q38 = q_q[23];
    assign Q41 = q_q[24]; assign Q42 = q_q[25]; assign Q43 = q_q[26]; assign Q44 = q_q[27];
    assign Q45 = q_q[28]; assign Q46 = q_q[29]; assign Q47 = q_q[30]; assign Q48 = q_q[31];
    assign Q51 = q_q[32]; assign Q52 = q_q[33]; assign Q53 = q_q[34]; assign Q54 = q_q[35];
    assign Q55 = q_q[36]; assign Q56 = q_q[37]; assign Q57 = q_q[38]; assign Q58 = q_q[39];
    assign Q61 = q_q[40]; assign Q62 = q_q[41]; assign Q63 = q_q[42]; assign Q64 = q_q[43];
    assign Q65 = q_q[44]; assign Q66 = q_q[45]; assign Q67 = q_q[46]; assign Q68 = q_q[47];
    assign Q71 = q_q[48]; assign Q72 = q_q[49]; assign Q73 = q_q[50]; assign Q74 = q_q[51];
    assign Q75 = q_q[52]; assign Q76 = q_q[53]; assign Q77 = q_q[54]; assign Q78 = q_q[55];
    assign Q81 = q_q[56]; assign Q82 = q_q[57]; assign Q83 = q_q[58]; assign Q84 = q_q[59];
    assign Q85 = q_q[60]; assign Q86 = q_q[61]; assign Q87 = q_q[62]; assign Q88 = q_q[63];

    assign out_enable = en_q[2];

    always_comb begin
        en_d = {en_q[1:0], enable};
        for (int i = 0; i < 64; i++) begin
            z1_d[i] = {{13{z_in[i][10]}}, z_in[i]};
            p_d[i]  = z1_q[i] * $signed({11'd0, recip(QT[i])});
`ifdef Y_QUANT_ROUND_EN
            // +2048 before the shift equals adding P[11] to P[22:12].
            q_d[i]  = 11'((p_q[i] + 24'sd2048) >>> 12);
`else
            q_d[i]  = 11'(p_q[i] >>> 12);
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q <= '0;
            for (int i = 0; i < 64; i++) begin
                z1_q[i] <= '0;
                p_q[i]  <= '0;
                q_q[i]  <= '0;
            end
        end else begin
            en_q <= en_d;
            for (int i = 0; i < 64; i++) begin
                z1_q[i] <= z1_d[i];
                p_q[i]  <= p_d[i];
                q_q[i]  <= q_d[i];
            end
        end
    end

endmodule

// File: tb/tb_y_quantizer.sv
// tb_y_quantizer: scoreboard bench for y_quantizer; expected blocks are queued at issue
// and a negedge monitor pops and compares them (values and arrival cycle) on out_enable.
module tb_y_quantizer;

    typedef logic [63:0][10:0] blk_t;
    typedef struct packed {
        logic [31:0] due;
        blk_t        q;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enable = 1'b0;
    blk_t z_drv = '0;
    wire [63:0][10:0] q_mon;
    wire out_enable;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int qr [64];
    int qt [64] = '{
        16, 11, 10, 16, 24, 40, 51, 61,
        12, 12, 14, 19, 26, 58, 60, 55,
        14, 13, 16, 24, 40, 57, 69, 56,
        14, 17, 22, 29, 51, 87, 80, 62,
        18, 22, 37, 56, 68, 109, 103, 77,
        24, 35, 55, 64, 81, 104, 113, 92,
        49, 64, 78, 87, 103, 121, 120, 101,
        72, 92, 95, 98, 112, 100, 103, 99
    };

    // Single-coefficient directed vectors: index, Z, expected rounded, expected floored.
    int d_idx [11] = '{0, 0, 2, 7, 7, 63, 1, 5, 5, 63, 32};
    int d_z   [11] = '{1023, -1024, 1023, 30, -31, 100, -1024, 500, -500, -100, 9};
    int d_rnd [11] = '{64, -64, 102, 0, -1, 1, -93, 12, -12, -1, 1};
    int d_trn [11] = '{63, -64, 102, 0, -1, 1, -93, 12, -13, -2, 0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    y_quantizer dut (
        .clk(clk), .rst(rst), .enable(enable), .out_enable(out_enable),
        .Z11(z_drv[0]),  .Z12(z_drv[1]),  .Z13(z_drv[2]),  .Z14(z_drv[3]),
        .Z15(z_drv[4]),  .Z16(z_drv[5]),  .Z17(z_drv[6]),  .Z18(z_drv[7]),
        .Z21(z_drv[8]),  .Z22(z_drv[9]),  .Z23(z_drv[10]), .Z24(z_drv[11]),
        .Z25(z_drv[12]), .Z26(z_drv[13]), .Z27(z_drv[14]), .Z28(z_drv[15]),
        .Z31(z_drv[16]), .Z32(z_drv[17]), .Z33(z_drv[18]), .Z34(z_drv[19]),
        .Z35(z_drv[20]), .Z36(z_drv[21]), .Z37(z_drv[22]), .Z38(z_drv[23]),
        .Z41(z_drv[24]), .Z42(z_drv[25]), .Z43(z_drv[26]), .Z44(z_drv[27]),
        .Z45(z_drv[28]), .Z46(z_drv[29]), .Z47(z_drv[30]), .Z48(z_drv[31]),
        .Z51(z_drv[32]), .Z52(z_drv[33]), .Z53(z_drv[34]), .Z54(z_drv[35]),
        .Z55(z_drv[36]), .Z56(z_drv[37]), .Z57(z_drv[38]), .Z58(z_drv[39]),
        .Z61(z_drv[40]), .Z62(z_drv[41]), .Z63(z_drv[42]), .Z64(z_drv[43]),
        .Z65(z_drv[44]), .Z66(z_drv[45]), .Z67(z_drv[46]), .Z68(z_drv[47]),
        .Z71(z_drv[48]), .Z72(z_drv[49]), .Z73(z_drv[50]), .Z74(z_drv[51]),
        .Z75(z_drv[52]), .Z76(z_drv[53]), .Z77(z_drv[54]), .Z78(z_drv[55]),
        .Z81(z_drv[56]), .Z82(z_drv[57]), .Z83(z_drv[58]), .Z84(z_drv[59]),
        .Z85(z_drv[60]), .Z86(z_drv[61]), .Z87(z_drv[62]), .Z88(z_drv[63]),
        .Q11(q_mon[0]),  .Q12(q_mon[1]),  .Q13(q_mon[2]),  .Q14(q_mon[3]),
        .Q15(q_mon[4]),  .Q16(q_mon[5]),  .Q17(q_mon[6]),  .Q18(q_mon[7]),
        .Q21(q_mon[8]),  .Q22(q_mon[9]),  .Q23(q_mon[10]), .Q24(q_mon[11]),
        .Q25(q_mon[12]), .Q26(q_mon[13]), .Q27(q_mon[14]), .Q28(q_mon[15]),
        .Q31(q_mon[16]), .Q32(q_mon[17]), .Q33(q_mon[18]), .Q34(q_mon[19]),
        .Q35(q_mon[20]), .Q36(q_mon[21]), .Q37(q_mon[22]), .Q38(q_mon[23]),
        .Q41(q_mon[24]), .Q42(q_mon[25]), .Q43(q_mon[26]), .Q44(q_mon[27]),
        .Q45(q_mon[28]), .Q46(q_mon[29]), .Q47(q_mon[30]), .Q48(q_mon[31]),
        .Q51(q_mon[32]), .Q52(q_mon[33]), .Q53(q_mon[34]), .Q54(q_mon[35]),
        .Q55(q_mon[36]), .Q56(q_mon[37]), .Q57(q_mon[38]), .Q58(q_mon[39]),
        .Q61(q_mon[40]), .Q62(q_mon[41]), .Q63(q_mon[42]), .Q64(q_mon[43]),
        .Q65(q_mon[44]), .Q66(q_mon[45]), .Q67(q_mon[46]), .Q68(q_mon[47]),
        .Q71(q_mon[48]), .Q72(q_mon[49]), .Q73(q_mon[50]), .Q74(q_mon[51]),
        .Q75(q_mon[52]), .Q76(q_mon[53]), .Q77(q_mon[54]), .Q78(q_mon[55]),
        .Q81(q_mon[56]), .Q82(q_mon[57]), .Q83(q_mon[58]), .Q84(q_mon[59]),
        .Q85(q_mon[60]), .Q86(q_mon[61]), .Q87(q_mon[62]), .Q88(q_mon[63])
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic blk_t model(input blk_t z);
        blk_t r;
        int p;
        for (int k = 0; k < 64; k++) begin
            p = int'($signed(z[k])) * qr[k];
`ifdef Y_QUANT_ROUND_EN
            p = p + 2048;
`endif
            r[k] = 11'(p >>> 12);
        end
        return r;
    endfunction

    task automatic send(input blk_t b, input logic en, input blk_t exp_b);
        exp_t e;
        @(negedge clk);
        z_drv  = b;
        enable = en;
        if (en) begin
            e.due = 32'(cyc + 3);
            e.q   = exp_b;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send('0, 1'b0, '0);
    endtask

    task automatic check_all_zero(input string name);
        for (int k = 0; k < 64; k++) check(name, int'(q_mon[k]), 0);
        check({name, "_out_enable"}, int'(out_enable), 0);
    endtask

    // Monitor: every out_enable pulse must match the oldest queued block, on its due cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_enable) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_enable cycle %0d actual 1 required 0", cyc);
            end else begin
                e = exp_q.pop_front();
                check("arrival_cycle", cyc, int'(e.due));
                for (int k = 0; k < 64; k++)
                    check($sformatf("Q%0d%0d", k / 8 + 1, k % 8 + 1),
                          $signed(q_mon[k]), $signed(e.q[k]));
            end
        end
    end

    initial begin
        blk_t b;
        blk_t e;
        int drain;
        for (int k = 0; k < 64; k++) qr[k] = $rtoi(4096.0 / qt[k] + 0.5);

        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("reset_state");
        rst = 1'b0;

        // Zero block, single-cycle enable.
        send('0, 1'b1, '0);
        idle(4);

        // Directed single-coefficient vectors, back to back.
        for (int i = 0; i < 11; i++) begin
            b = '0;
            e = '0;
            b[d_idx[i]] = 11'(d_z[i]);
`ifdef Y_QUANT_ROUND_EN
            e[d_idx[i]] = 11'(d_rnd[i]);
`else
            e[d_idx[i]] = 11'(d_trn[i]);
`endif
            send(b, 1'b1, e);
        end
        idle(4);

        // Streaming: 5 consecutive blocks, a 2-cycle gap, then 3 more.
        for (int n = 0; n < 8; n++) begin
            if (n == 5) idle(2);
            for (int k = 0; k < 64; k++) b[k] = 11'($urandom_range(0, 2047));
            send(b, 1'b1, model(b));
        end
        idle(4);

        // Reset mid-flight with nonzero outputs showing.
        for (int k = 0; k < 64; k++) b[k] = 11'd1023;
        repeat (3) send(b, 1'b1, model(b));
        @(negedge clk);
        enable = 1'b0;
        #2 rst = 1'b1;
        #1 check_all_zero("async_reset");
        exp_q.delete();
        repeat (3) @(negedge clk);
        check_all_zero("reset_hold");
        rst = 1'b0;
        idle(4);
        for (int k = 0; k < 64; k++) b[k] = 11'(k * 31 - 1000);
        send(b, 1'b1, model(b));
        idle(4);

        // Random sweep with random enable.
        for (int n = 0; n < 1000; n++) begin
            for (int k = 0; k < 64; k++) b[k] = 11'($urandom_range(0, 2047));
            send(b, 1'($urandom_range(0, 3) != 0), model(b));
        end
        enable = 1'b0;

        drain = 0;
        while (exp_q.size() != 0 && drain < 10) begin
            @(negedge clk);
            drain++;
        end
        check("drain_pending_blocks", exp_q.size(), 0);
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/y_quantizer.md
# y_quantizer

Luma (Y) quantization stage of the JPEG encoder datapath. It sits between the 2-D DCT and the zig-zag/Huffman stages. It takes one 8x8 block of signed DCT coefficients in parallel and divides each coefficient by the standard JPEG luminance quantization table entry. Division uses a fixed-point reciprocal multiply: `(Z * round(4096/Q)) >>> 12`, with rounding. Results come out of a 3-stage register pipeline with a valid strobe.

## Interface
Parameters: none. The quantization table is fixed and held as internal constants.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous reset, active-high.
- `enable` in 1: marks the `Z` inputs as a valid block in this cycle.
- `Z11`..`Z88` in 11 each, 64 ports: signed two's-complement DCT coefficients. `Zrc` = row r, column c (1..8).
- `Q11`..`Q88` out 11 each, 64 ports: signed quantized coefficients, same indexing.
- `out_enable` out 1: `Q` outputs hold the result of a block that entered with `enable`=1.

## Operation
Luma table, rows 1..8, columns 1..8:
- row 1: 16 11 10 16 24 40 51 61
- row 2: 12 12 14 19 26 58 60 55
- row 3: 14 13 16 24 40 57 69 56
- row 4: 14 17 22 29 51 87 80 62
- row 5: 18 22 37 56 68 109 103 77
- row 6: 24 35 55 64 81 104 113 92
- row 7: 49 64 78 87 103 121 120 101
- row 8: 72 92 95 98 112 100 103 99

Arithmetic, per element:
- Reciprocal: `QRrc = round_to_nearest(4096/Qrc)`, an unsigned constant of at most 13 bits. Examples: 16→256, 10→410, 11→372, 99→41, 61→67.
- Stage 1: register `Zrc`, sign-extended to 24 bits.
- Stage 2: register the signed 24-bit product `P = Zrc_ext * QRrc`. It cannot overflow, since |P| < 2^19.
- Stage 3, with rounding enabled: `Qrc = P[22:12] + P[11]`. This is arithmetic shift right by 12 with round-half-up toward +inf; the sum is truncated to 11 bits and the result always fits.
- Output is interpreted as signed 11-bit.

Pipeline behaviour:
- The pipeline is free-running: every stage loads on every rising edge regardless of `enable`.
- `enable` travels through a parallel 3-flop delay chain; the last flop drives `out_enable`.
- A block may be presented every cycle, back-to-back, at full throughput.
- `enable`=0 cycles still flow data through the pipeline, but `out_enable` stays 0 for those slots.

## Timing
- Latency is 3 rising edges. Inputs sampled at edge N appear on `Q` after edge N+2, with `out_enable`=1 if `enable` was 1 at edge N.
- `out_enable` and `Q` stay valid for exactly one cycle per accepted block.
- Reset (async, `rst`=1): all pipeline registers, all `Q` outputs and `out_enable` clear to 0 immediately, and hold while `rst`=1.
- Reset mid-flight: in-flight blocks are discarded. The first valid output comes 3 edges after the first `enable`=1 sampled following reset release.
- No backpressure. Downstream must accept every `out_enable` pulse.

## Configuration
- Macro `Y_QUANT_ROUND_EN`.
- Defined: stage 3 rounds as `P[22:12] + P[11]`.
- Undefined: stage 3 truncates as `P[22:12]`, i.e. floor (arithmetic shift). This removes the 64 rounding adders.
- Reciprocal constants and latency are identical in both builds.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle with nonzero `Q` → all `Q` and `out_enable` read 0 before the next edge. They stay 0 until 3 edges after the first `enable`.
- Zero block: all `Z`=0, single-cycle `enable` → exactly one `out_enable` pulse 3 edges later, all `Q`=0.
- Extremes, with `Y_QUANT_ROUND_EN`:
  - `Z11`=1023 → `Q11`=64.
  - `Z11`=-1024 → `Q11`=-64.
  - `Z13`=1023 → `Q13`=102 (1023·410=419430; 419430>>12=102, bit11=0).
- Rounding boundary: `Z18`=30 → 0; `Z18`=-31 → -1; `Z88`=100 → 1. Without the macro: `Z11`=1023 → 63.
- Streaming: 5 consecutive random blocks, `enable` held high → 5 consecutive `out_enable` cycles. Each `Q` matches the reference model for its block in order. An `enable` gap produces an `out_enable` gap of the same width.
- Random sweep: 1000 random signed blocks with random `enable` → all 64 outputs match the model `(Z*round(4096/Q) + 2048) >>> 12`, truncated to 11 bits.
